// File: rtl/ifid_hold_latch.sv
// IF/ID pipeline register with fetch-hold control: stall/flush arbitration,
// HALT drain tracking and a sticky runaway-stall watchdog.
module ifid_hold_latch #(
  parameter logic [15:0] NOP_INSTR = 16'h0800,
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr_in,
  input  logic [15:0]      pc_inc_in,
  input  logic             fetch_valid,
  input  logic             STALL,
  input  logic             FLUSH,
  output logic [15:0]      instr_out,
  output logic [15:0]      pc_inc_out,
  output logic             valid_out,
  output logic             pc_write_en,
  output logic             idex_bubble,
  output logic             draining,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_err
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t state;
  logic   hold;
  logic   halt_seen;

  assign hold      = STALL && !FLUSH;
  assign halt_seen = fetch_valid && (instr_in[15:11] == 5'b00000);

  always_comb begin
    pc_write_en = 1'b0;
    idex_bubble = FLUSH || STALL;
    draining    = (state == DRAIN);
    if (state == RUN) pc_write_en = !hold;
    else              pc_write_en = FLUSH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out    <= NOP_INSTR;
      pc_inc_out   <= '0;
      valid_out    <= 1'b0;
      state        <= RUN;
      stall_cycles <= '0;
      stall_err    <= 1'b0;
    end else begin
      // Watchdog samples the count before this edge's update, so it trails by one cycle.
      if (32'(stall_cycles) >= MAX_STALL) stall_err <= 1'b1;

      if (hold) begin
        if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      end else begin
        stall_cycles <= '0;
      end

      unique case (state)
        RUN: begin
          if (FLUSH) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
          end else if (!STALL) begin
            instr_out  <= fetch_valid ? instr_in : NOP_INSTR;
            pc_inc_out <= pc_inc_in;
            valid_out  <= fetch_valid;
            if (halt_seen) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Fetch is frozen: any non-stall cycle pushes a NOP behind the HALT.
          if (FLUSH || !STALL) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
          end
          if (FLUSH) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ifid_hold_latch.sv
// Directed self-checking bench for ifid_hold_latch.
module tb_ifid_hold_latch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr_in;
  logic [15:0] pc_inc_in;
  logic        fetch_valid;
  logic        STALL;
  logic        FLUSH;
  logic [15:0] instr_out;
  logic [15:0] pc_inc_out;
  logic        valid_out;
  logic        pc_write_en;
  logic        idex_bubble;
  logic        draining;
  logic [3:0]  stall_cycles;
  logic        stall_err;

  int checks   = 0;
  int failures = 0;

  ifid_hold_latch #(
    .NOP_INSTR(16'h0800),
    .MAX_STALL(8),
    .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .pc_inc_in(pc_inc_in),
    .fetch_valid(fetch_valid), .STALL(STALL), .FLUSH(FLUSH),
    .instr_out(instr_out), .pc_inc_out(pc_inc_out), .valid_out(valid_out),
    .pc_write_en(pc_write_en), .idex_bubble(idex_bubble), .draining(draining),
    .stall_cycles(stall_cycles), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_in = 16'h0; pc_inc_in = 16'h0; fetch_valid = 1'b0;
    STALL = 1'b0; FLUSH = 1'b0;
    cyc(); cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out} !== {16'h0800, 16'h0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_regs got %h/%h/%b want 0800/0000/0", instr_out, pc_inc_out, valid_out);
    end
    checks++;
    if ({stall_cycles, stall_err, draining, pc_write_en, idex_bubble} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_ctrl got cnt=%0d err=%b drn=%b pcwe=%b bub=%b want 0/0/0/1/0",
               stall_cycles, stall_err, draining, pc_write_en, idex_bubble);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_normal_load();
    instr_in = 16'h4105; pc_inc_in = 16'h0002; fetch_valid = 1'b1;
    #1;
    checks++;
    if ({pc_write_en, idex_bubble} !== 2'b10) begin
      failures++;
      $display("FAIL load_comb got pcwe=%b bub=%b want 1/0", pc_write_en, idex_bubble);
    end
    cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out} !== {16'h4105, 16'h0002, 1'b1}) begin
      failures++;
      $display("FAIL load_regs got %h/%h/%b want 4105/0002/1", instr_out, pc_inc_out, valid_out);
    end
  endtask

  task automatic test_raw_stall();
    STALL = 1'b1; instr_in = 16'h5A00; pc_inc_in = 16'h0004;
    for (int unsigned i = 1; i <= 2; i++) begin
      #1;
      checks++;
      if ({pc_write_en, idex_bubble} !== 2'b01) begin
        failures++;
        $display("FAIL stall_comb%0d got pcwe=%b bub=%b want 0/1", i, pc_write_en, idex_bubble);
      end
      cyc();
      checks++;
      if ({instr_out, pc_inc_out, stall_cycles} !== {16'h4105, 16'h0002, 4'(i)}) begin
        failures++;
        $display("FAIL stall_hold%0d got %h/%h cnt=%0d want 4105/0002 cnt=%0d",
                 i, instr_out, pc_inc_out, stall_cycles, i);
      end
    end
    STALL = 1'b0;
    cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out, stall_cycles} !== {16'h5A00, 16'h0004, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL stall_release got %h/%h/%b cnt=%0d want 5A00/0004/1 cnt=0",
               instr_out, pc_inc_out, valid_out, stall_cycles);
    end
  endtask

  task automatic test_flush_during_stall();
    STALL = 1'b1;
    cyc();
    FLUSH = 1'b1;
    #1;
    checks++;
    if ({pc_write_en, idex_bubble} !== 2'b11) begin
      failures++;
      $display("FAIL flush_comb got pcwe=%b bub=%b want 1/1", pc_write_en, idex_bubble);
    end
    cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out, stall_cycles} !== {16'h0800, 16'h0004, 1'b0, 4'd0}) begin
      failures++;
      $display("FAIL flush_regs got %h/%h/%b cnt=%0d want 0800/0004/0 cnt=0",
               instr_out, pc_inc_out, valid_out, stall_cycles);
    end
    STALL = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic test_fetch_invalid();
    instr_in = 16'h0000; pc_inc_in = 16'h0006; fetch_valid = 1'b0;
    cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out, draining} !== {16'h0800, 16'h0006, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fetch_invalid got %h/%h/%b drn=%b want 0800/0006/0 drn=0",
               instr_out, pc_inc_out, valid_out, draining);
    end
  endtask

  task automatic test_halt_drain();
    instr_in = 16'h0000; pc_inc_in = 16'h0008; fetch_valid = 1'b1;
    cyc();
    instr_in = 16'h4105; pc_inc_in = 16'h000A;
    #1;
    checks++;
    if ({instr_out, valid_out, draining, pc_write_en, idex_bubble} !== {16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL halt_latch got %h/%b drn=%b pcwe=%b bub=%b want 0000/1 drn=1 pcwe=0 bub=0",
               instr_out, valid_out, draining, pc_write_en, idex_bubble);
    end
    STALL = 1'b1;
    #1;
    checks++;
    if ({pc_write_en, idex_bubble} !== 2'b01) begin
      failures++;
      $display("FAIL drain_stall_comb got pcwe=%b bub=%b want 0/1", pc_write_en, idex_bubble);
    end
    cyc();
    checks++;
    if ({instr_out, valid_out, stall_cycles} !== {16'h0000, 1'b1, 4'd1}) begin
      failures++;
      $display("FAIL drain_stall_hold got %h/%b cnt=%0d want 0000/1 cnt=1", instr_out, valid_out, stall_cycles);
    end
    STALL = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      instr_in = 16'h1111 * 16'(i + 1);
      cyc();
      checks++;
      if ({instr_out, valid_out, draining, pc_write_en} !== {16'h0800, 1'b0, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL drain_nop%0d got %h/%b drn=%b pcwe=%b want 0800/0 drn=1 pcwe=0",
                 i, instr_out, valid_out, draining, pc_write_en);
      end
    end
  endtask

  task automatic test_halt_squash();
    FLUSH = 1'b1;
    #1;
    checks++;
    if ({pc_write_en, idex_bubble} !== 2'b11) begin
      failures++;
      $display("FAIL squash_comb got pcwe=%b bub=%b want 1/1", pc_write_en, idex_bubble);
    end
    cyc();
    FLUSH = 1'b0; instr_in = 16'h3C3C; pc_inc_in = 16'h0020;
    #1;
    checks++;
    if ({instr_out, valid_out, draining, pc_write_en} !== {16'h0800, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL squash_state got %h/%b drn=%b pcwe=%b want 0800/0 drn=0 pcwe=1",
               instr_out, valid_out, draining, pc_write_en);
    end
    cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out} !== {16'h3C3C, 16'h0020, 1'b1}) begin
      failures++;
      $display("FAIL squash_reload got %h/%h/%b want 3C3C/0020/1", instr_out, pc_inc_out, valid_out);
    end
  endtask

  task automatic test_watchdog();
    STALL = 1'b1;
    for (int unsigned i = 1; i <= 9; i++) begin
      cyc();
      checks++;
      if ({stall_cycles, stall_err} !== {4'(i), (i == 9)}) begin
        failures++;
        $display("FAIL wd_cycle%0d got cnt=%0d err=%b want cnt=%0d err=%b",
                 i, stall_cycles, stall_err, i, (i == 9));
      end
    end
    repeat (8) cyc();
    checks++;
    if ({stall_cycles, stall_err, instr_out} !== {4'd15, 1'b1, 16'h3C3C}) begin
      failures++;
      $display("FAIL wd_saturate got cnt=%0d err=%b %h want cnt=15 err=1 3C3C",
               stall_cycles, stall_err, instr_out);
    end
    STALL = 1'b0;
    cyc();
    checks++;
    if ({stall_cycles, stall_err} !== {4'd0, 1'b1}) begin
      failures++;
      $display("FAIL wd_sticky got cnt=%0d err=%b want cnt=0 err=1", stall_cycles, stall_err);
    end
  endtask

  task automatic test_async_reset();
    STALL = 1'b1;
    cyc(); cyc();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_out, pc_inc_out, valid_out, stall_cycles, stall_err, draining} !==
        {16'h0800, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got %h/%h/%b cnt=%0d err=%b drn=%b want 0800/0000/0 cnt=0 err=0 drn=0",
               instr_out, pc_inc_out, valid_out, stall_cycles, stall_err, draining);
    end
    STALL = 1'b0;
    cyc();
    rst_n = 1'b1;
    instr_in = 16'h7001; pc_inc_in = 16'h0030; fetch_valid = 1'b1;
    cyc();
    checks++;
    if ({instr_out, pc_inc_out, valid_out} !== {16'h7001, 16'h0030, 1'b1}) begin
      failures++;
      $display("FAIL post_reset_load got %h/%h/%b want 7001/0030/1", instr_out, pc_inc_out, valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_raw_stall();
    test_flush_during_stall();
    test_fetch_invalid();
    test_halt_drain();
    test_halt_squash();
    test_watchdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifid_hold_latch.md
Name: ifid_hold_latch

Overview:
IF/ID pipeline register and fetch-hold controller. It consumes the decode-stage STALL and the EX-stage branch/jump FLUSH, and drives three things: the latched instruction to decode, the PC write enable, and the bubble request into ID/EX. It also tracks HALT draining and watches for runaway stalls.
It sits between the fetch stage and the decode stage.

Parameters:
NOP_INSTR, 16'h0800, encoding loaded into IF/ID on reset, flush and post-HALT drain.
MAX_STALL, 8, consecutive stall cycles at which stall_err is set.
CNT_W, 4, width of stall_cycles; must satisfy 2^CNT_W-1 >= MAX_STALL.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
instr_in  in  16  instruction from fetch.
pc_inc_in  in  16  PC+2 from fetch.
fetch_valid  in  1  fetch output is valid this cycle.
STALL  in  1  RAW hazard in decode; hold IF/ID and PC.
FLUSH  in  1  taken branch/jump resolved in EX; kill IF and ID.
instr_out  out  16  instruction presented to decode.
pc_inc_out  out  16  PC+2 presented to decode.
valid_out  out  1  instr_out is a real instruction.
pc_write_en  out  1  PC register may update (combinational).
idex_bubble  out  1  ID/EX loads zeroed controls (combinational).
draining  out  1  HALT latched; fetch frozen.
stall_cycles  out  CNT_W  consecutive stall count, saturating at 2^CNT_W-1.
stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - instr_out=NOP_INSTR, pc_inc_out=0, valid_out=0.
  - State RUN, stall_cycles=0, stall_err=0.
  - Combinational outputs then evaluate per the rules below with state RUN.
- States: RUN, DRAIN. Priority per cycle is FLUSH > STALL > normal load.
- RUN, FLUSH=1:
  - IF/ID loads NOP_INSTR, valid_out=0, pc_inc_out unchanged.
  - pc_write_en=1 so the branch target is written.
  - idex_bubble=1.
  - stall_cycles cleared.
- RUN, STALL=1, FLUSH=0:
  - IF/ID holds all fields. pc_write_en=0, idex_bubble=1.
  - stall_cycles increments (saturating).
- RUN, normal:
  - IF/ID loads instr_in and pc_inc_in; valid_out=fetch_valid.
  - If fetch_valid=0, instr_out loads NOP_INSTR.
  - pc_write_en=1, idex_bubble=0, stall_cycles cleared.
- HALT detection: on a normal load where fetch_valid=1 and instr_in[15:11]==5'b00000, the next state is DRAIN. The HALT itself is latched normally.
- DRAIN:
  - pc_write_en=0; draining=1.
  - While STALL=1 (and FLUSH=0): hold the latched HALT, idex_bubble=1, count stalls.
  - First non-stall cycle: IF/ID loads NOP_INSTR with valid_out=0, so the HALT moves into ID/EX. It then stays NOP; fetch inputs are ignored.
  - FLUSH=1 in DRAIN: the older branch was taken, so the HALT is squashed. Load NOP_INSTR, return to RUN, pc_write_en=1.
  - DRAIN is left only by FLUSH or reset.
- Watchdog: stall_err sets the cycle after stall_cycles reaches MAX_STALL. It is sticky until reset and has no effect on the datapath.
- Simultaneous STALL and FLUSH: FLUSH wins; no hold, counter cleared.
- Reset asserted mid-stall or in DRAIN: immediate return to reset values. Nothing latched survives.
- pc_inc_out is only meaningful when valid_out=1.

Test Plan:
- Reset then normal load: release rst_n; instr_in=16'h4105, pc_inc_in=16'h0002, fetch_valid=1 -> next edge instr_out=16'h4105, pc_inc_out=2, valid_out=1, pc_write_en=1, idex_bubble=0.
- Two-cycle RAW stall: latch 16'h4105, then STALL=1 for 2 cycles with instr_in=16'h5A00 -> instr_out stays 16'h4105. pc_write_en=0 and idex_bubble=1 for both cycles; stall_cycles goes 1 then 2. On STALL=0, 16'h5A00 loads and stall_cycles=0.
- FLUSH during STALL: STALL=1 and FLUSH=1 together -> instr_out=16'h0800, valid_out=0, pc_write_en=1, idex_bubble=1, stall_cycles=0.
- HALT drain: load 16'h0000, then feed 16'h4105 -> draining=1, pc_write_en=0, instr_out becomes 16'h0800/valid_out=0 and stays so for 5+ cycles despite fetch input.
- HALT squashed: in DRAIN, pulse FLUSH=1 -> state RUN, draining=0, pc_write_en=1; the next normal load latches instr_in.
- Watchdog and async reset: hold STALL=1 for 9 cycles -> stall_err=1 after stall_cycles hits 8, and stays after STALL drops. Assert rst_n low mid-clock -> stall_err=0 and instr_out=16'h0800 immediately, with no clock edge.
